mem_access_ctrl: RTL and testbench

MEM-stage data-memory access controller, the consumer of the EX/MEM pipeline register outputs. It turns the latched EX result into a data-bus load/store transaction, stalls the pipeline until the bus responds, and forwards the aligned, extended result plus register-write control toward MEM/WB. Non-memory instructions pass through combinationally with zero added latency.

---
 rtl/mem_access_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: EX/MEM result -> bus load/store, stall until ram_ready.
// Optional alignment checking is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     result_in,
    input  logic                      write_reg_en_in,
    input  logic [REG_ADDR_WIDTH-1:0] write_reg_addr_in,
    input  logic                      mem_read_en_in,
    input  logic                      mem_write_en_in,
    input  logic [1:0]                mem_size_in,
    input  logic                      mem_sign_ext_in,
    input  logic [DATA_WIDTH-1:0]     mem_write_data_in,
    output logic                      ram_en,
    output logic                      ram_write_en,
    output logic [DATA_WIDTH-1:0]     ram_addr,
    output logic [3:0]                ram_byte_sel,
    output logic [DATA_WIDTH-1:0]     ram_write_data,
    input  logic                      ram_ready,
    input  logic [DATA_WIDTH-1:0]     ram_read_data,
    output logic [DATA_WIDTH-1:0]     result_out,
    output logic                      write_reg_en_out,
    output logic [REG_ADDR_WIDTH-1:0] write_reg_addr_out,
    output logic                      stall_req,
    output logic                      bus_err,
    output logic                      align_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                r_state;
    logic [DATA_WIDTH-1:0]     r_addr;
    logic [3:0]                r_sel;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [1:0]                r_size;
    logic                      r_sign;
    logic                      r_is_store;
    logic                      r_wr_en;
    logic [REG_ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [7:0]                r_cnt;

    logic                  w_mem_op;
    logic                  w_misalign;
    logic                  w_timeout;
    logic [3:0]            w_sel;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load_data;

    assign w_mem_op  = mem_read_en_in | mem_write_en_in;
    assign w_timeout = (r_cnt == 8'(TIMEOUT_CYCLES - 1));

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = ((mem_size_in == 2'b01) && result_in[0]) ||
                        (mem_size_in[1] && (result_in[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_sel   = 4'b1111;
        w_wdata = mem_write_data_in;
        case (mem_size_in)
            2'b00: begin
                w_sel   = 4'b0001 << result_in[1:0];
                w_wdata = {4{mem_write_data_in[7:0]}};
            end
            2'b01: begin
                w_sel   = result_in[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{mem_write_data_in[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = ram_read_data[7:0];
            2'd1:    w_byte = ram_read_data[15:8];
            2'd2:    w_byte = ram_read_data[23:16];
            default: w_byte = ram_read_data[31:24];
        endcase
        w_half = r_addr[1] ? ram_read_data[31:16] : ram_read_data[15:0];
        case (r_size)
            2'b00:   w_load_data = {{24{r_sign & w_byte[7]}}, w_byte};
            2'b01:   w_load_data = {{16{r_sign & w_half[15]}}, w_half};
            default: w_load_data = ram_read_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_sel      <= '0;
            r_wdata    <= '0;
            r_size     <= '0;
            r_sign     <= 1'b0;
            r_is_store <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_data     <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mem_op && !w_misalign) begin
                        r_addr     <= result_in;
                        r_sel      <= w_sel;
                        r_wdata    <= w_wdata;
                        r_size     <= mem_size_in;
                        r_sign     <= mem_sign_ext_in;
                        r_is_store <= mem_write_en_in;
                        r_wr_en    <= write_reg_en_in;
                        r_wr_addr  <= write_reg_addr_in;
                        r_cnt      <= '0;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // ram_ready takes priority over a timeout landing in the same cycle
                    if (ram_ready) begin
                        r_data  <= w_load_data;
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        r_data  <= '0;
                        r_wr_en <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ram_en             = 1'b0;
        ram_write_en       = 1'b0;
        ram_addr           = '0;
        ram_byte_sel       = '0;
        ram_write_data     = '0;
        result_out         = '0;
        write_reg_en_out   = 1'b0;
        write_reg_addr_out = '0;
        stall_req          = 1'b0;
        bus_err            = 1'b0;
        align_err          = 1'b0;
        // Outputs are forced low while reset is held, including the IDLE pass-through path
        if (rst) begin
            case (r_state)
                S_IDLE: begin
                    if (w_mem_op) begin
                        align_err = w_misalign;
                        stall_req = ~w_misalign;
                    end else begin
                        result_out         = result_in;
                        write_reg_en_out   = write_reg_en_in;
                        write_reg_addr_out = write_reg_addr_in;
                    end
                end
                S_BUSY: begin
                    ram_en         = 1'b1;
                    ram_write_en   = r_is_store;
                    ram_addr       = {r_addr[DATA_WIDTH-1:2], 2'b00};
                    ram_byte_sel   = r_sel;
                    ram_write_data = r_wdata;
                    stall_req      = 1'b1;
                    bus_err        = ~ram_ready & w_timeout;
                end
                S_DONE: begin
                    result_out         = r_is_store ? r_addr : r_data;
                    write_reg_en_out   = r_wr_en & ~r_is_store;
                    write_reg_addr_out = r_wr_addr;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (TIMEOUT_CYCLES=4).
// Alignment scenario expectations follow MEM_ALIGN_CHECK_EN.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] result_in;
    logic        write_reg_en_in;
    logic [4:0]  write_reg_addr_in;
    logic        mem_read_en_in;
    logic        mem_write_en_in;
    logic [1:0]  mem_size_in;
    logic        mem_sign_ext_in;
    logic [31:0] mem_write_data_in;
    logic        ram_en;
    logic        ram_write_en;
    logic [31:0] ram_addr;
    logic [3:0]  ram_byte_sel;
    logic [31:0] ram_write_data;
    logic        ram_ready;
    logic [31:0] ram_read_data;
    logic [31:0] result_out;
    logic        write_reg_en_out;
    logic [4:0]  write_reg_addr_out;
    logic        stall_req;
    logic        bus_err;
    logic        align_err;

    int n_cmp = 0;
    int n_err = 0;

    mem_access_ctrl #(
        .DATA_WIDTH(32),
        .REG_ADDR_WIDTH(5),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .result_in(result_in),
        .write_reg_en_in(write_reg_en_in),
        .write_reg_addr_in(write_reg_addr_in),
        .mem_read_en_in(mem_read_en_in),
        .mem_write_en_in(mem_write_en_in),
        .mem_size_in(mem_size_in),
        .mem_sign_ext_in(mem_sign_ext_in),
        .mem_write_data_in(mem_write_data_in),
        .ram_en(ram_en),
        .ram_write_en(ram_write_en),
        .ram_addr(ram_addr),
        .ram_byte_sel(ram_byte_sel),
        .ram_write_data(ram_write_data),
        .ram_ready(ram_ready),
        .ram_read_data(ram_read_data),
        .result_out(result_out),
        .write_reg_en_out(write_reg_en_out),
        .write_reg_addr_out(write_reg_addr_out),
        .stall_req(stall_req),
        .bus_err(bus_err),
        .align_err(align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        result_in         = '0;
        write_reg_en_in   = 1'b0;
        write_reg_addr_in = '0;
        mem_read_en_in    = 1'b0;
        mem_write_en_in   = 1'b0;
        mem_size_in       = 2'b00;
        mem_sign_ext_in   = 1'b0;
        mem_write_data_in = '0;
        ram_ready         = 1'b0;
        ram_read_data     = '0;
    endtask

    task automatic test_reset();
        result_in = 32'h0000_CAFE; write_reg_en_in = 1'b1; write_reg_addr_in = 5'd9;
        #1;
        n_cmp++; if (result_out !== 32'h0) begin n_err++; $display("FAIL rst_result got %h exp 00000000", result_out); end
        n_cmp++; if (write_reg_en_out !== 1'b0) begin n_err++; $display("FAIL rst_wren got %b exp 0", write_reg_en_out); end
        n_cmp++; if (stall_req !== 1'b0 || ram_en !== 1'b0) begin n_err++; $display("FAIL rst_ctrl got stall=%b ram_en=%b exp 0/0", stall_req, ram_en); end
        @(negedge clk); rst = 1'b1;
        clear_inputs();
    endtask

    task automatic test_passthrough();
        step();
        result_in = 32'h1234_5678; write_reg_en_in = 1'b1; write_reg_addr_in = 5'd3;
        @(negedge clk);
        n_cmp++; if (result_out !== 32'h1234_5678) begin n_err++; $display("FAIL pt_result got %h exp 12345678", result_out); end
        n_cmp++; if (write_reg_en_out !== 1'b1 || write_reg_addr_out !== 5'd3) begin n_err++; $display("FAIL pt_wreg got en=%b addr=%0d exp 1/3", write_reg_en_out, write_reg_addr_out); end
        n_cmp++; if (stall_req !== 1'b0 || ram_en !== 1'b0) begin n_err++; $display("FAIL pt_ctrl got stall=%b ram_en=%b exp 0/0", stall_req, ram_en); end
        step(); clear_inputs();
    endtask

    task automatic test_word_load();
        mem_read_en_in = 1'b1; mem_size_in = 2'b10; result_in = 32'h0000_0100;
        write_reg_en_in = 1'b1; write_reg_addr_in = 5'd7;
        @(negedge clk);
        n_cmp++; if (stall_req !== 1'b1 || ram_en !== 1'b0) begin n_err++; $display("FAIL wl_idle got stall=%b ram_en=%b exp 1/0", stall_req, ram_en); end
        n_cmp++; if (result_out !== 32'h0 || write_reg_en_out !== 1'b0) begin n_err++; $display("FAIL wl_idle_out got res=%h en=%b exp 0/0", result_out, write_reg_en_out); end
        step();
        @(negedge clk);
        n_cmp++; if (ram_en !== 1'b1 || ram_write_en !== 1'b0 || stall_req !== 1'b1) begin n_err++; $display("FAIL wl_busy got ram_en=%b we=%b stall=%b exp 1/0/1", ram_en, ram_write_en, stall_req); end
        n_cmp++; if (ram_addr !== 32'h100 || ram_byte_sel !== 4'b1111) begin n_err++; $display("FAIL wl_bus got addr=%h sel=%b exp 00000100/1111", ram_addr, ram_byte_sel); end
        step();
        ram_ready = 1'b1; ram_read_data = 32'hDEAD_BEEF;
        @(negedge clk);
        n_cmp++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL wl_busy2 got stall=%b exp 1", stall_req); end
        step();
        ram_ready = 1'b0; ram_read_data = '0;
        @(negedge clk);
        n_cmp++; if (result_out !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wl_done_res got %h exp deadbeef", result_out); end
        n_cmp++; if (write_reg_en_out !== 1'b1 || write_reg_addr_out !== 5'd7) begin n_err++; $display("FAIL wl_done_wreg got en=%b addr=%0d exp 1/7", write_reg_en_out, write_reg_addr_out); end
        n_cmp++; if (stall_req !== 1'b0 || ram_en !== 1'b0) begin n_err++; $display("FAIL wl_done_ctrl got stall=%b ram_en=%b exp 0/0", stall_req, ram_en); end
        step(); clear_inputs();
        @(negedge clk);
        n_cmp++; if (ram_en !== 1'b0 || stall_req !== 1'b0) begin n_err++; $display("FAIL wl_after got ram_en=%b stall=%b exp 0/0", ram_en, stall_req); end
    endtask

    task automatic test_byte_load();
        logic [31:0] t_addr [3] = '{32'h103, 32'h103, 32'h102};
        logic [1:0]  t_size [3] = '{2'b00, 2'b00, 2'b01};
        logic        t_sign [3] = '{1'b1, 1'b0, 1'b1};
        logic [31:0] t_rd   [3] = '{32'h8000_0000, 32'h8000_0000, 32'h8001_1234};
        logic [3:0]  t_sel  [3] = '{4'b1000, 4'b1000, 4'b1100};
        logic [31:0] t_res  [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001};
        for (int i = 0; i < 3; i++) begin
            step();
            mem_read_en_in = 1'b1; result_in = t_addr[i]; mem_size_in = t_size[i];
            mem_sign_ext_in = t_sign[i]; write_reg_en_in = 1'b1; write_reg_addr_in = 5'd4;
            step();
            ram_ready = 1'b1; ram_read_data = t_rd[i];
            @(negedge clk);
            n_cmp++; if (ram_byte_sel !== t_sel[i]) begin n_err++; $display("FAIL ld%0d_sel got %b exp %b", i, ram_byte_sel, t_sel[i]); end
            step();
            ram_ready = 1'b0;
            @(negedge clk);
            n_cmp++; if (result_out !== t_res[i]) begin n_err++; $display("FAIL ld%0d_res got %h exp %h", i, result_out, t_res[i]); end
            step(); clear_inputs();
        end
    endtask

    task automatic test_half_store();
        step();
        mem_write_en_in = 1'b1; mem_size_in = 2'b01; result_in = 32'h202;
        mem_write_data_in = 32'h0000_ABCD; write_reg_en_in = 1'b1; write_reg_addr_in = 5'd5;
        step();
        ram_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (ram_byte_sel !== 4'b1100 || ram_addr !== 32'h200) begin n_err++; $display("FAIL hs_bus got sel=%b addr=%h exp 1100/00000200", ram_byte_sel, ram_addr); end
        n_cmp++; if (ram_write_data !== 32'hABCD_ABCD || ram_write_en !== 1'b1) begin n_err++; $display("FAIL hs_data got wd=%h we=%b exp abcdabcd/1", ram_write_data, ram_write_en); end
        step();
        ram_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (write_reg_en_out !== 1'b0 || result_out !== 32'h202) begin n_err++; $display("FAIL hs_done got en=%b res=%h exp 0/00000202", write_reg_en_out, result_out); end
        step(); clear_inputs();
        mem_write_en_in = 1'b1; mem_size_in = 2'b00; result_in = 32'h201; mem_write_data_in = 32'h1234_565A;
        step();
        ram_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (ram_byte_sel !== 4'b0010 || ram_write_data !== 32'h5A5A_5A5A) begin n_err++; $display("FAIL bs_bus got sel=%b wd=%h exp 0010/5a5a5a5a", ram_byte_sel, ram_write_data); end
        step(); clear_inputs();
        step();
    endtask

    task automatic test_timeout();
        mem_read_en_in = 1'b1; mem_size_in = 2'b10; result_in = 32'h300;
        write_reg_en_in = 1'b1; write_reg_addr_in = 5'd6;
        step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (bus_err !== (i == 3) || ram_en !== 1'b1) begin n_err++; $display("FAIL to_busy%0d got bus_err=%b ram_en=%b exp %b/1", i, bus_err, ram_en, (i == 3)); end
            step();
        end
        // a late ram_ready in DONE must be ignored
        ram_ready = 1'b1; ram_read_data = 32'h5555_5555;
        @(negedge clk);
        n_cmp++; if (result_out !== 32'h0 || write_reg_en_out !== 1'b0) begin n_err++; $display("FAIL to_done got res=%h en=%b exp 0/0", result_out, write_reg_en_out); end
        n_cmp++; if (stall_req !== 1'b0 || bus_err !== 1'b0) begin n_err++; $display("FAIL to_done_ctrl got stall=%b bus_err=%b exp 0/0", stall_req, bus_err); end
        step(); clear_inputs();
    endtask

    task automatic test_reset_midbusy();
        mem_read_en_in = 1'b1; mem_size_in = 2'b10; result_in = 32'h400;
        step();
        @(negedge clk);
        n_cmp++; if (ram_en !== 1'b1) begin n_err++; $display("FAIL rb_busy got ram_en=%b exp 1", ram_en); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (ram_en !== 1'b0 || stall_req !== 1'b0) begin n_err++; $display("FAIL rb_async got ram_en=%b stall=%b exp 0/0", ram_en, stall_req); end
        clear_inputs();
        @(negedge clk); rst = 1'b1;
        step();
    endtask

    task automatic test_align();
        mem_read_en_in = 1'b1; mem_size_in = 2'b10; result_in = 32'h101;
        write_reg_en_in = 1'b1; write_reg_addr_in = 5'd8;
`ifdef MEM_ALIGN_CHECK_EN
        @(negedge clk);
        n_cmp++; if (align_err !== 1'b1 || stall_req !== 1'b0 || ram_en !== 1'b0) begin n_err++; $display("FAIL al_idle got aerr=%b stall=%b ram_en=%b exp 1/0/0", align_err, stall_req, ram_en); end
        n_cmp++; if (result_out !== 32'h0 || write_reg_en_out !== 1'b0) begin n_err++; $display("FAIL al_out got res=%h en=%b exp 0/0", result_out, write_reg_en_out); end
        step(); clear_inputs();
        @(negedge clk);
        n_cmp++; if (align_err !== 1'b0 || ram_en !== 1'b0) begin n_err++; $display("FAIL al_after got aerr=%b ram_en=%b exp 0/0", align_err, ram_en); end
`else
        step();
        @(negedge clk);
        n_cmp++; if (ram_addr !== 32'h100 || ram_byte_sel !== 4'b1111) begin n_err++; $display("FAIL al_bus got addr=%h sel=%b exp 00000100/1111", ram_addr, ram_byte_sel); end
        n_cmp++; if (align_err !== 1'b0) begin n_err++; $display("FAIL al_err got %b exp 0", align_err); end
        ram_ready = 1'b1; ram_read_data = 32'h0BAD_F00D;
        step();
        ram_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (result_out !== 32'h0BAD_F00D) begin n_err++; $display("FAIL al_res got %h exp 0badf00d", result_out); end
        step(); clear_inputs();
`endif
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        test_reset();
        test_passthrough();
        test_word_load();
        test_byte_load();
        test_half_store();
        test_timeout();
        test_reset_midbusy();
        test_align();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
